// File: rtl/cal_pkg.sv
// Constants and types shared by the acoustic localisation chain (tdoa_capture, cal_position).
// Keeping them in one place means the tick rate and sound speed agree across blocks.
package cal_pkg;

    localparam int TICK_HZ         = 10_000;
    localparam int L_MM            = 100;
    // 340 m/s at 0.1 ms per tick
    localparam int VEL_MM_PER_TICK = 34;
    localparam int DLY_W           = 4;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ORDER,
        ERR_TIMEOUT
    } err_code_t;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        REPORT,
        HOLDOFF
    } state_t;

endpackage

// File: rtl/tdoa_capture_if.sv
// Microphone inputs and delay-report outputs of tdoa_capture.
// The slave side is the capture block; the master side is whoever drives the mics.
interface tdoa_capture_if;
    import cal_pkg::*;

    logic [3:0]       mic_hit;
    logic             arm_en;
    logic [DLY_W-1:0] delay12;
    logic [DLY_W-1:0] delay13;
    logic [DLY_W-1:0] delay14;
    logic             ena;
    logic             err;
    logic [1:0]       err_code;
    logic             busy;

    modport master (
        output mic_hit, arm_en,
        input  delay12, delay13, delay14, ena, err, err_code, busy
    );

    modport slave (
        input  mic_hit, arm_en,
        output delay12, delay13, delay14, ena, err, err_code, busy
    );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 and pulses tick for one clk on the wrap.
// clr restarts the count so the next tick lands a full DIV cycles later.
module tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1)) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tdoa_capture.sv
// Timestamps the first rising edge of each of four microphones and reports
// mic1-relative delays with an ena strobe, or an err pulse for unusable events.
module tdoa_capture #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICK_HZ       = cal_pkg::TICK_HZ,
    parameter int MAX_DELAY     = 15,
    parameter int HOLDOFF_TICKS = 2000
) (
    input  logic           clk,
    input  logic           rst_n,
    tdoa_capture_if.slave  bus
);
    import cal_pkg::*;

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int HW  = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS) : 1;

    logic [3:0]            mic_sync_p0, mic_sync_p1, mic_prev_p2;
    logic [3:0]            mic_rise;
    state_t                state, state_nxt;
    logic                  tick, tick_clr;
    logic [4:0]            tcnt;
    logic [HW-1:0]         hcnt;
    logic [3:0]            seen, seen_nxt;
    logic [3:0][DLY_W-1:0] ts, ts_nxt;
    logic                  timeout, rpt_go;
    logic [DLY_W-1:0]      delay12_r, delay13_r, delay14_r;
    logic                  ena_r, err_r, busy_r;
    err_code_t             err_code_r;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // stage p2: rising edge from the third synchroniser flop
    assign mic_rise = mic_sync_p1 & ~mic_prev_p2;

    always_comb begin
        state_nxt = state;
        seen_nxt  = seen;
        ts_nxt    = ts;
        tick_clr  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: state_nxt = ARMED;
            ARMED: begin
                seen_nxt = '0;
                ts_nxt   = '0;
                if (bus.arm_en && (|mic_rise)) begin
                    seen_nxt  = mic_rise;
                    state_nxt = CAPTURE;
                    tick_clr  = 1'b1;
                end
            end
            CAPTURE: begin
                for (int i = 0; i < 4; i++) begin
                    if (mic_rise[i] && !seen[i]) begin
                        seen_nxt[i] = 1'b1;
                        ts_nxt[i]   = tcnt[DLY_W-1:0];
                    end
                end
                // overflow wins even if the last mic arrives in the same cycle
                timeout = tick && (tcnt == 5'(MAX_DELAY));
                if (!bus.arm_en) begin
                    state_nxt = ARMED;
                end else if (timeout || (seen_nxt == 4'hF)) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: state_nxt = HOLDOFF;
            HOLDOFF: begin
                if (tick && (hcnt == HW'(HOLDOFF_TICKS - 1))) begin
                    state_nxt = ARMED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Report outputs are registered on entry to REPORT so ena follows the last edge by one clk.
    assign rpt_go = (state == CAPTURE) && (state_nxt == REPORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mic_sync_p0 <= '0;
            mic_sync_p1 <= '0;
            mic_prev_p2 <= '0;
            state       <= IDLE;
            seen        <= '0;
            ts          <= '0;
            tcnt        <= '0;
            hcnt        <= '0;
            delay12_r   <= '0;
            delay13_r   <= '0;
            delay14_r   <= '0;
            ena_r       <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            busy_r      <= 1'b0;
        end else begin
            mic_sync_p0 <= bus.mic_hit;
            mic_sync_p1 <= mic_sync_p0;
            mic_prev_p2 <= mic_sync_p1;
            state       <= state_nxt;
            seen        <= seen_nxt;
            ts          <= ts_nxt;
            busy_r      <= (state_nxt != ARMED);
            ena_r       <= 1'b0;
            err_r       <= 1'b0;
            if (tick_clr) begin
                tcnt <= '0;
            end else if ((state == CAPTURE) && tick) begin
                tcnt <= tcnt + 5'd1;
            end
            if (state == REPORT) begin
                hcnt <= '0;
            end else if ((state == HOLDOFF) && tick) begin
                hcnt <= hcnt + HW'(1);
            end
            if (rpt_go) begin
                if (timeout) begin
                    err_r      <= 1'b1;
                    err_code_r <= ERR_TIMEOUT;
                end else if (ts_nxt[0] != '0) begin
                    err_r      <= 1'b1;
                    err_code_r <= ERR_ORDER;
                end else begin
                    ena_r      <= 1'b1;
                    err_code_r <= ERR_NONE;
                    delay12_r  <= ts_nxt[1];
                    delay13_r  <= ts_nxt[2];
                    delay14_r  <= ts_nxt[3];
                end
            end
        end
    end

    assign bus.delay12  = delay12_r;
    assign bus.delay13  = delay13_r;
    assign bus.delay14  = delay14_r;
    assign bus.ena      = ena_r;
    assign bus.err      = err_r;
    assign bus.err_code = err_code_r;
    assign bus.busy     = busy_r;

endmodule

// File: doc/tdoa_capture.md
Name: tdoa_capture

Overview:
- Front end of the acoustic localisation chain: watches four microphone threshold-detector outputs and timestamps each microphone's first rising edge in 0.1 ms ticks.
- Produces the mic1-relative arrival delays delay12, delay13 and delay14, 4 bits each, plus a clean one-cycle ena strobe that starts cal_position.
- Rejects events that would give cal_position garbage: mic1 not first, or a microphone missing inside the window.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 10_000, timestamp resolution; 0.1 ms matches vel = 34 mm per tick.
- MAX_DELAY, 15, largest reportable delay in ticks; must fit 4 bits.
- HOLDOFF_TICKS, 2000, dead time after a report (200 ms) so echoes are not re-captured.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mic_hit  in  4  raw detector outputs, asynchronous; bit0 = mic1 … bit3 = mic4.
- arm_en  in  1  level; capture allowed only while high.
- delay12  out  4  ticks from mic1 edge to mic2 edge.
- delay13  out  4  ticks from mic1 edge to mic3 edge.
- delay14  out  4  ticks from mic1 edge to mic4 edge.
- ena  out  1  one-cycle pulse, registered, when a valid delay set is on delay1x.
- err  out  1  one-cycle pulse on a rejected event.
- err_code  out  2  cause of the last error: 0 none, 1 mic1 not first, 2 timeout.
- busy  out  1  high in every state except ARMED.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Input synchronisation: mic_hit passes through a 2-flop synchroniser per bit. Rising-edge detect uses a third flop.
  - Edge-to-detection latency is 3 clk.
- Prescaler: counts 0..DIV-1 with DIV = CLK_HZ/TICK_HZ and emits tick on the wrap. It is cleared on entry to CAPTURE.
- tcnt: 5-bit tick counter, cleared on entry to CAPTURE, incremented on each tick.
- seen[3:0]: per-microphone capture flags. ts[i]: 4-bit timestamp per microphone.
- State IDLE: waits 1 cycle after reset, then goes to ARMED.
- State ARMED: seen = 0.
  - If arm_en is low, stay.
  - On any detected edge, go to CAPTURE. Every mic with an edge in that cycle gets seen = 1 and ts = 0.
- State CAPTURE:
  - A detected edge on a mic with seen = 0 sets seen and ts = tcnt.
  - Later edges on an already-seen mic are ignored.
  - Edges on several mics in the same cycle all get the same timestamp.
  - When seen = 4'hF, go to REPORT.
  - If tcnt would pass MAX_DELAY with seen ≠ 4'hF, go to REPORT with the timeout flag set.
  - Timeout has priority if the last mic edge and the overflow happen in the same cycle.
  - arm_en falling aborts back to ARMED with no ena and no err.
- State REPORT (1 cycle):
  - Timeout: err = 1, err_code = 2.
  - Else if ts[0] ≠ 0, i.e. mic1 was not among the first edge: err = 1, err_code = 1.
  - Else: delay12 = ts[1], delay13 = ts[2], delay14 = ts[3], ena = 1, err_code = 0.
  - delay1x are updated only on a valid report and hold their values otherwise.
  - Next state is HOLDOFF.
- State HOLDOFF: counts HOLDOFF_TICKS ticks, with the prescaler free-running and edges ignored, then goes to ARMED.
- Latency: ena asserts 1 clk after the cycle in which the 4th edge is detected.
- ena and err are never high in the same cycle. Each is exactly 1 clk wide.
- Reset mid-operation returns immediately to the reset values. Held delay1x are lost.
- Width rules: DIV and HOLDOFF counter widths come from $clog2. The timestamp is a truncation of tcnt, which is safe because tcnt ≤ MAX_DELAY whenever it is stored.

Decomposition:
- Shared package cal_pkg holds:
  - constants TICK_HZ = 10_000 and L_MM = 100;
  - VEL_MM_PER_TICK = 34, so cal_position and this block agree;
  - delay width DLY_W = 4;
  - enum err_code {ERR_NONE, ERR_ORDER, ERR_TIMEOUT};
  - state enum {IDLE, ARMED, CAPTURE, REPORT, HOLDOFF}.
- One sub-module is natural: tick_gen (prescaler with clear input and tick output), reusable by the display/refresh logic.

Test Plan:
- Bench settings: CLK_HZ = 100, TICK_HZ = 10 (DIV = 10), HOLDOFF_TICKS = 4.
- Valid event: mic1 at t0, mic2 +3 ticks, mic3 +7, mic4 +5 -> one ena pulse, delay12 = 3, delay13 = 7, delay14 = 5, err = 0.
- Simultaneous edges: all four mics rise in the same clk -> ena, all delays = 0.
- Order error: mic3 first, then mic1 2 ticks later, mic2 and mic4 afterwards -> err pulse, err_code = 1, no ena, delay1x keep their previous values (3, 7, 5).
- Timeout: mic1, mic2, mic3 only, mic4 never rises -> err with err_code = 2 after 16 ticks; busy stays high for HOLDOFF_TICKS = 4 ticks, then ARMED.
- Holdoff and echo: a second full burst arriving 2 ticks after a report is ignored; the same burst 6 ticks after the report produces a second ena.
- Reset and arm: rst_n low mid-CAPTURE -> all outputs 0 within the cycle. arm_en low with edges present -> no capture and busy = 0; arm_en dropping during CAPTURE -> return to ARMED, no ena, no err.
